// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg : status codes, register indices, FSM states and icodes shared by
//           the Y86-64 SEQ pipeline stages.
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  // A memory error overrides fetch status; unknown codes collapse to INS.
  function automatic logic [2:0] eff_stat(input logic [2:0] stat, input logic memerror);
    if (memerror)
      return STAT_ADR;
    if (stat == STAT_AOK || stat == STAT_HLT || stat == STAT_ADR || stat == STAT_INS)
      return stat;
    return STAT_INS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile_array.sv
// ----------------------------------------------------------------------------
// wb_regfile_array : NREG x 64 storage, two combinational reads, two writes
//                    with the M port winning on an index collision.
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module wb_regfile_array #(
  parameter int NREG = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rd_a,
  output logic [63:0] rd_b
);

  logic [63:0] regs [NREG];

  // Index 4'hF never matches an entry, so RNONE writes and reads fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREG; i++) begin
        if (dst_m == 4'(i))
          regs[i] <= val_m;
        else if (dst_e == 4'(i))
          regs[i] <= val_e;
      end
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == 4'(i))
        rd_a = regs[i];
      if (src_b == 4'(i))
        rd_b = regs[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile : Y86-64 SEQ write-back register file with RUN/HALT status FSM
//              and retired-instruction counter. Option: WB_REGFILE_BYPASS_EN.
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module wb_regfile
  import y86_pkg::*;
#(
  parameter int NREG  = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [2:0]       stat_in,
  input  logic             memerror,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  output logic [63:0]      valA,
  output logic [63:0]      valB,
  output logic [2:0]       stat_out,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t      state;
  logic [2:0]  eff;
  logic        commit;
  logic [63:0] rd_a;
  logic [63:0] rd_b;

  assign eff    = eff_stat(stat_in, memerror);
  assign commit = instr_valid && (state == S_RUN) && (eff == STAT_AOK);

  wb_regfile_array #(
    .NREG (NREG)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit),
    .dst_e (dstE),
    .val_e (valE),
    .dst_m (dstM),
    .val_m (valM),
    .src_a (srcA),
    .src_b (srcB),
    .rd_a  (rd_a),
    .rd_b  (rd_b)
  );

`ifdef WB_REGFILE_BYPASS_EN
  always_comb begin
    valA = rd_a;
    valB = rd_b;
    if (commit && srcA != RNONE) begin
      if (srcA == dstM)
        valA = valM;
      else if (srcA == dstE)
        valA = valE;
    end
    if (commit && srcB != RNONE) begin
      if (srcB == dstM)
        valB = valM;
      else if (srcB == dstE)
        valB = valE;
    end
  end
`else
  assign valA = rd_a;
  assign valB = rd_b;
`endif

  // HLT retires the halt instruction itself; ADR/INS do not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      stat_out <= STAT_AOK;
      halted   <= 1'b0;
      retired  <= '0;
    end else if (instr_valid && state == S_RUN) begin
      case (eff)
        STAT_AOK: begin
          retired <= retired + 1'b1;
        end
        STAT_HLT: begin
          retired  <= retired + 1'b1;
          stat_out <= STAT_HLT;
          halted   <= 1'b1;
          state    <= S_HALT;
        end
        default: begin
          stat_out <= eff;
          halted   <= 1'b1;
          state    <= S_HALT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile : directed scoreboard bench for wb_regfile (CNT_W shrunk to
//                 exercise counter wrap).
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_regfile;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [2:0]    stat_in;
  logic          memerror;
  logic [3:0]    srcA, srcB, dstE, dstM;
  logic [63:0]   valE, valM;
  logic [63:0]   valA, valB;
  logic [2:0]    stat_out;
  logic          halted;
  logic [CW-1:0] retired;

  int tests  = 0;
  int failed = 0;

  logic [63:0] exp_q [$];
  string       tag_q [$];

  // reference model
  logic [63:0]   m_r [15];
  logic [2:0]    m_stat;
  logic          m_halt;
  logic [CW-1:0] m_ret;
  logic [CW-1:0] saved_ret;

  always #5 clk = ~clk;

  wb_regfile #(.NREG(15), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stat_in(stat_in),
    .memerror(memerror), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valA(valA), .valB(valB), .stat_out(stat_out),
    .halted(halted), .retired(retired)
  );

  task automatic push(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (obs === e) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    return (idx == 4'hF) ? 64'd0 : m_r[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_r[i] = '0;
    m_stat = 3'd1;
    m_halt = 1'b0;
    m_ret  = '0;
  endtask

  task automatic model_edge();
    logic [2:0] e;
    if (!instr_valid || m_halt) return;
    e = memerror ? 3'd3 : ((stat_in >= 3'd1 && stat_in <= 3'd4) ? stat_in : 3'd4);
    if (e == 3'd1) begin
      if (dstE != 4'hF) m_r[dstE] = valE;
      if (dstM != 4'hF) m_r[dstM] = valM;
      m_ret = m_ret + 1'b1;
    end else begin
      if (e == 3'd2) m_ret = m_ret + 1'b1;
      m_stat = e;
      m_halt = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    push({tag, "_valA"}, m_read(srcA));
    push({tag, "_valB"}, m_read(srcB));
    push({tag, "_stat"}, 64'(m_stat));
    push({tag, "_halted"}, 64'(m_halt));
    push({tag, "_retired"}, 64'(m_ret));
    check(valA);
    check(valB);
    check(64'(stat_out));
    check(64'(halted));
    check(64'(retired));
  endtask

  task automatic do_instr(input string tag, input logic [2:0] st, input logic me,
                          input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm,
                          input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk);
    instr_valid = 1'b1; stat_in = st; memerror = me;
    dstE = de; valE = ve; dstM = dm; valM = vm;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    instr_valid = 1'b0; memerror = 1'b0; stat_in = 3'd1;
    srcA = sa; srcB = sb;
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; stat_in = 3'd1; memerror = 1'b0;
    srcA = 4'd0; srcB = 4'd4; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");

    do_instr("aok_e2", 3'd1, 1'b0, 4'd2, 64'h1234, 4'hF, 64'h0, 4'd2, 4'd4);
    do_instr("dst_collide", 3'd1, 1'b0, 4'd4, 64'h8, 4'd4, 64'hFF, 4'd4, 4'd2);
    do_instr("edge_regs", 3'd1, 1'b0, 4'd0, 64'hDEAD_BEEF_0000_0001, 4'd14, 64'hA5A5_5A5A_F0F0_0F0F, 4'd0, 4'd14);
    do_instr("m_only", 3'd1, 1'b0, 4'hF, 64'h77, 4'd7, 64'h0123_4567_89AB_CDEF, 4'd7, 4'hF);

    // strobe low: nothing changes
    @(negedge clk);
    dstE = 4'd6; valE = 64'h66; dstM = 4'hF; srcA = 4'd6; srcB = 4'd2;
    @(posedge clk);
    model_edge();
    #1;
    check_all("idle");

    saved_ret = m_ret;
    for (int i = 0; i < 16; i++)
      do_instr("nop_loop", 3'd1, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 4'd4, 4'd7);
    push("retired_wrap", 64'(saved_ret));
    check(64'(retired));

    do_instr("memerror", 3'd1, 1'b1, 4'd3, 64'h5, 4'hF, 64'h0, 4'd3, 4'd2);
    do_instr("halt_frozen", 3'd1, 1'b0, 4'd3, 64'h9, 4'd2, 64'h99, 4'd3, 4'd2);
    async_reset("reset_after_adr");

    do_instr("pre_hlt", 3'd1, 1'b0, 4'd5, 64'hABC, 4'hF, 64'h0, 4'd5, 4'd4);
    do_instr("hlt", 3'd2, 1'b0, 4'd5, 64'h1, 4'hF, 64'h0, 4'd5, 4'd4);
    async_reset("reset_after_hlt");

    do_instr("bad_stat", 3'd0, 1'b0, 4'd1, 64'h11, 4'hF, 64'h0, 4'd1, 4'd4);
    async_reset("reset_after_ins");

    // same-cycle read of a register being written
    do_instr("pre_byp", 3'd1, 1'b0, 4'd1, 64'h3, 4'hF, 64'h0, 4'd1, 4'd4);
    @(negedge clk);
    instr_valid = 1'b1; stat_in = 3'd1; memerror = 1'b0;
    dstE = 4'd1; valE = 64'h7; dstM = 4'd4; valM = 64'h9; srcA = 4'd1; srcB = 4'd4;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    push("byp_valA", 64'h7);
    push("byp_valB", 64'h9);
`else
    push("byp_valA", 64'h3);
    push("byp_valB", 64'h0);
`endif
    check(valA);
    check(valB);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    check_all("post_byp");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
